// File: rtl/fifo_pkg.sv
// Shared definitions for the gray-pointer async FIFO and its read-side stream consumer.
package fifo_pkg;

    localparam int unsigned FIFO_DSIZE = 8;
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer; the head entry drives the stream data directly.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = FIFO_DSIZE
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [DSIZE-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [DSIZE-1:0] data_o,
    output logic [OCC_W-1:0] occ_o
);

    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == '0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                occ_d = occ_q + OCC_W'(1);
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - OCC_W'(1);
            end
            2'b11: begin
                // Simultaneous push/pop keeps occupancy; the new word lands behind any tail.
                if (occ_q == OCC_W'(1)) begin
                    head_d = data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign valid_o = (occ_q != '0);
    assign data_o  = head_q;
    assign occ_o   = occ_q;

    overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && (occ_q == OCC_W'(SKID_DEPTH))));
    underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && (occ_q == '0)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read-side consumer: pops words and re-presents them as a valid/ready stream.
// Define FIFO_RD_STREAM_STATS_EN to add the stall_cnt/starve_cnt saturating counters.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = FIFO_DSIZE,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clkb,
    input  logic             rstnb,
    input  logic             en,
    output logic             rreqb,
    input  logic [DSIZE-1:0] rdatb,
    input  logic             emptyb,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic             idle,
    output logic [CNTW-1:0]  rd_cnt
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [CNTW-1:0]  stall_cnt,
    output logic [CNTW-1:0]  starve_cnt
`endif
);

    localparam logic [OCC_W:0] LevelMax = SKID_DEPTH[OCC_W:0];

    rd_state_e        state_q, state_d;
    logic             inflight_q, inflight_d;
    logic [CNTW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   level;
    logic             pop;

    fifo_rd_skid #(
        .DSIZE(DSIZE)
    ) u_skid (
        .clk_i  (clkb),
        .rst_ni (rstnb),
        .push_i (inflight_q),
        .data_i (rdatb),
        .pop_i  (pop),
        .valid_o(m_valid),
        .data_o (m_data),
        .occ_o  (occ)
    );

    assign pop = m_valid & m_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = StDrain;
            StDrain: begin
                // Re-enabling keeps in-flight data; the capture path is independent of state.
                if (en) begin
                    state_d = StRun;
                end else if ((occ == '0) && !inflight_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Buffer space after this cycle's pop must cover the word the request will return.
    always_comb begin
        level      = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
        rreqb      = rstnb && (state_q == StRun) && !emptyb && (level < LevelMax);
        inflight_d = rreqb;
        rd_cnt_d   = rd_cnt_q + CNTW'(pop);
    end

    always_ff @(posedge clkb) begin
        if (!rstnb) begin
            state_q    <= StIdle;
            inflight_q <= 1'b0;
            rd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    assign idle   = (state_q == StIdle);
    assign rd_cnt = rd_cnt_q;

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
        if ((state_q == StRun) && emptyb && (occ == '0) && (starve_cnt_q != '1)) begin
            starve_cnt_d = starve_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clkb) begin
        if (!rstnb) begin
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign starve_cnt = starve_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: vector table for stream/backpressure/drain, then
// hand-written empty, mid-stream reset and counter-wrap sequences.
module tb_fifo_rd_stream;

    logic       clkb;
    logic       rstnb;
    logic       en;
    logic       rreqb;
    logic [7:0] rdatb;
    logic       emptyb;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       idle;
    logic [3:0] rd_cnt;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [3:0] stall_cnt;
    logic [3:0] starve_cnt;
`endif

    fifo_rd_stream #(
        .DSIZE(8),
        .CNTW (4)
    ) dut (
        .clkb   (clkb),
        .rstnb  (rstnb),
        .en     (en),
        .rreqb  (rreqb),
        .rdatb  (rdatb),
        .emptyb (emptyb),
        .m_valid(m_valid),
        .m_data (m_data),
        .m_ready(m_ready),
        .idle   (idle),
`ifdef FIFO_RD_STREAM_STATS_EN
        .stall_cnt (stall_cnt),
        .starve_cnt(starve_cnt),
`endif
        .rd_cnt (rd_cnt)
    );

    initial clkb = 1'b0;
    always #5 clkb = ~clkb;

    typedef struct {
        int en;
        int emptyb;
        int rdy;
        int req;
        int valid;
        int data;
        int idle;
        int cnt;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] data_seq;
    vec_t       vecs[21];

    function automatic vec_t mk(int e, int emp, int r, int q, int v, int d, int i, int c);
        vec_t t;
        t.en = e; t.emptyb = emp; t.rdy = r; t.req = q;
        t.valid = v; t.data = d; t.idle = i; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: a request seen before the edge returns the next word after it.
    task automatic cyc();
        logic req;
        #2;
        req = rreqb;
        @(posedge clkb);
        #1;
        if (req) begin
            rdatb    = data_seq;
            data_seq = data_seq + 8'd1;
        end else begin
            rdatb = 8'hEE;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         pops;
        int         got;
        logic [7:0] exp_word;

        rstnb    = 1'b0;
        en       = 1'b0;
        emptyb   = 1'b1;
        m_ready  = 1'b0;
        rdatb    = 8'hEE;
        data_seq = 8'h10;
        cyc();
        cyc();
        #1;
        chk("rst_rreqb", 32'(rreqb), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_rd_cnt", 32'(rd_cnt), 0);
        rstnb = 1'b1;

        // Startup, 5-cycle backpressure, then drain with a word still in flight.
        vecs[0]  = mk(1, 0, 1, 0, 0, 8'h00, 1, 0);
        vecs[1]  = mk(1, 0, 1, 1, 0, 8'h00, 0, 0);
        vecs[2]  = mk(1, 0, 1, 1, 0, 8'h00, 0, 0);
        vecs[3]  = mk(1, 0, 1, 1, 1, 8'h10, 0, 0);
        vecs[4]  = mk(1, 0, 1, 1, 1, 8'h11, 0, 1);
        vecs[5]  = mk(1, 0, 1, 1, 1, 8'h12, 0, 2);
        vecs[6]  = mk(1, 0, 0, 0, 1, 8'h13, 0, 3);
        vecs[7]  = mk(1, 0, 0, 0, 1, 8'h13, 0, 3);
        vecs[8]  = mk(1, 0, 0, 0, 1, 8'h13, 0, 3);
        vecs[9]  = mk(1, 0, 0, 0, 1, 8'h13, 0, 3);
        vecs[10] = mk(1, 0, 0, 0, 1, 8'h13, 0, 3);
        vecs[11] = mk(1, 0, 1, 1, 1, 8'h13, 0, 3);
        vecs[12] = mk(1, 0, 1, 1, 1, 8'h14, 0, 4);
        vecs[13] = mk(1, 0, 1, 1, 1, 8'h15, 0, 5);
        vecs[14] = mk(0, 0, 1, 1, 1, 8'h16, 0, 6);
        vecs[15] = mk(0, 0, 0, 0, 1, 8'h17, 0, 7);
        vecs[16] = mk(0, 0, 0, 0, 1, 8'h17, 0, 7);
        vecs[17] = mk(0, 0, 1, 0, 1, 8'h17, 0, 7);
        vecs[18] = mk(0, 0, 1, 0, 1, 8'h18, 0, 8);
        vecs[19] = mk(0, 0, 1, 0, 0, 8'h00, 0, 9);
        vecs[20] = mk(0, 0, 1, 0, 0, 8'h00, 1, 9);

        for (int i = 0; i < 21; i++) begin
            en      = vecs[i].en[0];
            emptyb  = vecs[i].emptyb[0];
            m_ready = vecs[i].rdy[0];
            #1;
            chk($sformatf("vec%0d_rreqb", i), 32'(rreqb), vecs[i].req);
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), vecs[i].valid);
            if (vecs[i].valid != 0) begin
                chk($sformatf("vec%0d_m_data", i), 32'(m_data), vecs[i].data);
            end
            chk($sformatf("vec%0d_idle", i), 32'(idle), vecs[i].idle);
            chk($sformatf("vec%0d_rd_cnt", i), 32'(rd_cnt), vecs[i].cnt);
            cyc();
        end

        // Empty FIFO while running: no requests, then a single-cycle window yields one word.
        en      = 1'b1;
        emptyb  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("empty_rreqb", 32'(rreqb), 0);
            chk("empty_m_valid", 32'(m_valid), 0);
            cyc();
        end
        exp_word = data_seq;
        emptyb   = 1'b0;
        #1;
        chk("empty_pulse_rreqb", 32'(rreqb), 1);
        cyc();
        emptyb = 1'b1;
        got    = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("empty_after_rreqb", 32'(rreqb), 0);
            if (m_valid && m_ready) begin
                got++;
                chk("empty_word", 32'(m_data), 32'(exp_word));
            end
            cyc();
        end
        chk("empty_word_count", got, 1);

        // Mid-stream reset with the buffer full.
        emptyb  = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("pre_rst_m_valid", 32'(m_valid), 1);
        rstnb   = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("rst_cycle_rreqb", 32'(rreqb), 0);
        cyc();
        rstnb = 1'b1;
        en    = 1'b0;
        rdatb = 8'h5A;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_rd_cnt", 32'(rd_cnt), 0);
        chk("midrst_idle", 32'(idle), 1);
        cyc();
        #1;
        chk("midrst_rdatb_ignored", 32'(m_valid), 0);

        // 17 pops on a 4-bit counter, checking word order along the way.
        en       = 1'b1;
        emptyb   = 1'b0;
        m_ready  = 1'b1;
        exp_word = data_seq;
        pops     = 0;
        for (int i = 0; i < 100 && pops < 17; i++) begin
            #1;
            if (m_valid && m_ready) begin
                chk("wrap_word", 32'(m_data), 32'(exp_word));
                exp_word = exp_word + 8'd1;
                pops++;
            end
            cyc();
        end
        chk("wrap_pops", pops, 17);
        #1;
        chk("wrap_rd_cnt", 32'(rd_cnt), 1);

        // 20 stalled cycles: head held, stall counter saturates.
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("stall_m_valid", 32'(m_valid), 1);
            chk("stall_m_data", 32'(m_data), 32'(exp_word));
            cyc();
        end
`ifdef FIFO_RD_STREAM_STATS_EN
        #1;
        chk("stall_cnt_sat", 32'(stall_cnt), 15);
        chk("starve_cnt", 32'(starve_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
